// File: rtl/regfile_exec_pkg.sv
// Shared constants for the register-file execute controller: widths, opcodes,
// instruction field positions and FSM state encoding.
package regfile_exec_pkg;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 4;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;

  localparam int OP_MSB  = 19;
  localparam int OP_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 8;
  localparam int RB_MSB  = 7;
  localparam int RB_LSB  = 4;
  localparam int IMM_MSB = 11;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic is_write_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/alu20.sv
// Combinational 20-bit ALU. Ops 10-15 and NOP produce zero with no carry.
module alu20
  import regfile_exec_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [11:0]       imm12,
  output logic [DATA_W-1:0] y,
  output logic              carry
);

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: {carry, y} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        y     = a - b;
        carry = (a < b);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      // Shift amount is the imm4 field, which sits in the low nibble of imm12
      OP_SHL: y = a << imm12[3:0];
      OP_SHR: y = a >> imm12[3:0];
      OP_LDI: y = {8'h00, imm12};
      OP_MOV: y = a;
      default: begin
        y     = '0;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_exec_ctrl.sv
// Four-state execute controller (IDLE/READ/EXEC/WB) driving a 16x20 two-read,
// one-write register file; one instruction retires every four cycles.
module regfile_exec_ctrl
  import regfile_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inInstr,
  output logic [ADDR_W-1:0] rdAddrA,
  input  logic [DATA_W-1:0] rdDataA,
  output logic [ADDR_W-1:0] rdAddrB,
  input  logic [DATA_W-1:0] rdDataB,
  output logic              write,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry,
  output logic              illegal
);

  state_t state_q, state_d;

  logic [DATA_W-1:0] instr_p0;
  logic [DATA_W-1:0] opa_p1, opb_p1;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
  logic [3:0]        op;

  assign op = instr_p0[OP_MSB:OP_LSB];

  alu20 u_alu (
    .op    (op),
    .a     (opa_p1),
    .b     (opb_p1),
    .imm12 (instr_p0[IMM_MSB:IMM_LSB]),
    .y     (alu_y),
    .carry (alu_c)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (inValid) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Gating with rst abandons a pending write-back in the reset cycle itself
  assign inReady = (state_q == ST_IDLE) && !rst;
  assign write   = (state_q == ST_WB) && is_write_op(op) && !rst;
  assign done    = (state_q == ST_WB) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdAddrA <= '0;
      rdAddrB <= '0;
      wrAddr  <= '0;
      wrData  <= '0;
      result  <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && inValid) begin
        rdAddrA <= inInstr[RA_MSB:RA_LSB];
        rdAddrB <= inInstr[RB_MSB:RB_LSB];
      end
      if (state_q == ST_EXEC) begin
        result  <= alu_y;
        zero    <= (alu_y == '0);
        carry   <= alu_c;
        illegal <= (op > OP_MOV);
        if (is_write_op(op)) begin
          wrAddr <= instr_p0[RD_MSB:RD_LSB];
          wrData <= alu_y;
        end
      end
    end
  end

  // Accept / operand capture (stage boundary IDLE->READ->EXEC)
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && inValid) instr_p0 <= inInstr;
    if (state_q == ST_READ) begin
      opa_p1 <= rdDataA;
      opb_p1 <= rdDataB;
    end
  end

endmodule
